leaf_seed_dispenser: RTL and testbench

- Sits directly downstream of the 8-leaf seed-tree expander in the Picnic-on-SM4 signer.
- On the expander's one-cycle completion pulse, captures the 2048-bit leaf bundle and its round tag t.
- Streams the leaves to the per-party consumers over a valid/ready interface, one OUT_W-bit beat at a time.
- Frees the expander to start the next round while streaming is in progress.

---
 rtl/leaf_seed_dispenser.sv | 144 ++++++++++++++
 tb/tb_leaf_seed_dispenser.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_seed_dispenser.sv
`timescale 1ns/1ps
// Purpose: capture the 8-leaf seed bundle from the tree expander and stream it out one OUT_W beat at a time.
// Latency: the first beat is valid on the edge after the one that samples tree_set_end; the bundle drains back-to-back.
// Backpressure: seed_ready low holds the current beat stable; a bundle arriving while busy is dropped and flags overrun.
//
// Ports:
//   clk, reset (async, active-low)
//   seed_bundle/t_in/tree_set_end : bundle, round tag and one-cycle completion pulse from the expander
//   seed_data/seed_leaf/seed_beat/seed_t/seed_valid/seed_ready/seed_last : beat stream to the party consumers
//   busy : bundle held and not yet fully drained
//   overrun/clr_overrun : sticky drop flag and its synchronous clear
module leaf_seed_dispenser #(
    parameter int NUM_LEAVES = 8,
    parameter int LEAF_W     = 256,
    parameter int OUT_W      = 128
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_LEAVES*LEAF_W-1:0] seed_bundle,
    input  logic [7:0]                   t_in,
    input  logic                         tree_set_end,
    output logic [OUT_W-1:0]             seed_data,
    output logic [2:0]                   seed_leaf,
    output logic                         seed_beat,
    output logic [7:0]                   seed_t,
    output logic                         seed_valid,
    input  logic                         seed_ready,
    output logic                         seed_last,
    output logic                         busy,
    output logic                         overrun,
    input  logic                         clr_overrun
);

    localparam int BEATS     = LEAF_W / OUT_W;
    localparam int TOTAL     = NUM_LEAVES * BEATS;
    localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 0;
    // Single flat beat counter: {leaf, beat}. Advancing it by one steps the
    // beat first and carries into the leaf when the beat wraps.
    localparam int IDX_W     = BEAT_BITS + 3;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                         state_q;
    state_t                         state_d;
    logic [NUM_LEAVES*LEAF_W-1:0]   bundle_q;
    logic [7:0]                     t_q;
    logic [IDX_W-1:0]               idx_q;
    logic                           overrun_q;

    logic streaming;
    logic is_last;
    logic xfer;
    logic final_xfer;
    logic capture;
    logic drop;

    assign streaming  = (state_q == STREAM);
    assign is_last    = (idx_q == IDX_W'(TOTAL - 1));
    assign xfer       = streaming & seed_ready;
    assign final_xfer = xfer & is_last;
    // A new bundle is only accepted when the holding register is free or is
    // being freed by this very edge; that gives back-to-back bundles with no bubble.
    assign capture    = tree_set_end & (~streaming | final_xfer);
    assign drop       = tree_set_end & streaming & ~final_xfer;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) begin
            if (capture) begin
                state_d = STREAM;
            end
        end else begin
            if (final_xfer) begin
                state_d = capture ? STREAM : IDLE;
            end
        end
    end

    // Capture register, beat counter and sticky overrun
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bundle_q  <= '0;
            t_q       <= '0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (capture) begin
                bundle_q <= seed_bundle;
                t_q      <= t_in;
                idx_q    <= '0;
            end else if (xfer) begin
                idx_q    <= is_last ? '0 : idx_q + 1'b1;
            end
            // Set has priority over clear so a drop is never lost.
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (clr_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    // Output decode (registers only; seed_ready never reaches these)
    always_comb begin
        seed_valid = streaming;
        busy       = streaming;
        seed_last  = streaming & is_last;
        seed_data  = '0;
        if (streaming) begin
            // Beat g of the bundle sits at the g-th OUT_W slice counted from the MSB end.
            for (int i = 0; i < TOTAL; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    seed_data = bundle_q[(TOTAL-1-i)*OUT_W +: OUT_W];
                end
            end
        end
    end

    assign seed_leaf = idx_q[BEAT_BITS +: 3];
    assign seed_t    = t_q;
    assign overrun   = overrun_q;

    generate
        if (BEAT_BITS > 0) begin : g_beat
            assign seed_beat = idx_q[0];
        end else begin : g_no_beat
            assign seed_beat = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_leaf_seed_dispenser.sv
`timescale 1ns/1ps
module tb_leaf_seed_dispenser;

    typedef struct {
        logic [255:0] dat;
        logic [2:0]   leaf;
        logic         beat;
        logic [7:0]   t;
        logic         last;
    } exp_t;

    logic          clk;
    logic          reset;
    logic [2047:0] seed_bundle;
    logic [7:0]    t_in;
    logic          tree_set_end;
    logic          tree_set_end2;
    logic          seed_ready;
    logic          seed_ready2;
    logic          clr_overrun;

    logic [127:0]  seed_data;
    logic [2:0]    seed_leaf;
    logic          seed_beat;
    logic [7:0]    seed_t;
    logic          seed_valid;
    logic          seed_last;
    logic          busy;
    logic          overrun;

    logic [255:0]  seed_data2;
    logic [2:0]    seed_leaf2;
    logic          seed_beat2;
    logic [7:0]    seed_t2;
    logic          seed_valid2;
    logic          seed_last2;
    logic          busy2;
    logic          overrun2;

    exp_t sb[$];
    exp_t sb2[$];
    int   checks = 0;
    int   errors = 0;
    int   xfer_cnt = 0;
    int   xfer_cnt2 = 0;
    int   ready_mode = 0;
    logic pend_hold = 1'b0;

    leaf_seed_dispenser #(.NUM_LEAVES(8), .LEAF_W(256), .OUT_W(128)) dut (
        .clk(clk), .reset(reset), .seed_bundle(seed_bundle), .t_in(t_in),
        .tree_set_end(tree_set_end), .seed_data(seed_data), .seed_leaf(seed_leaf),
        .seed_beat(seed_beat), .seed_t(seed_t), .seed_valid(seed_valid),
        .seed_ready(seed_ready), .seed_last(seed_last), .busy(busy),
        .overrun(overrun), .clr_overrun(clr_overrun)
    );

    leaf_seed_dispenser #(.NUM_LEAVES(8), .LEAF_W(256), .OUT_W(256)) dut_wide (
        .clk(clk), .reset(reset), .seed_bundle(seed_bundle), .t_in(t_in),
        .tree_set_end(tree_set_end2), .seed_data(seed_data2), .seed_leaf(seed_leaf2),
        .seed_beat(seed_beat2), .seed_t(seed_t2), .seed_valid(seed_valid2),
        .seed_ready(seed_ready2), .seed_last(seed_last2), .busy(busy2),
        .overrun(overrun2), .clr_overrun(clr_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2047:0] rand_bundle();
        logic [2047:0] b;
        for (int i = 0; i < 64; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // Model for the 128-bit build: leaf k occupies [2047-256k -: 256], upper half first.
    task automatic push_narrow(input logic [2047:0] b, input logic [7:0] t);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            for (int bt = 0; bt < 2; bt++) begin
                e.dat  = {128'b0, b[2047 - k*256 - bt*128 -: 128]};
                e.leaf = k[2:0];
                e.beat = bt[0];
                e.t    = t;
                e.last = (k == 7) && (bt == 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic push_wide(input logic [2047:0] b, input logic [7:0] t);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.dat  = b[2047 - k*256 -: 256];
            e.leaf = k[2:0];
            e.beat = 1'b0;
            e.t    = t;
            e.last = (k == 7);
            sb2.push_back(e);
        end
    endtask

    // Ready driver: steady 1, or the repeating 1,0,0,1 pattern.
    initial begin
        logic [3:0] pat;
        int cyc;
        pat = 4'b1001;
        cyc = 0;
        seed_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            seed_ready = (ready_mode == 1) ? pat[cyc % 4] : 1'b1;
            cyc++;
        end
    end

    // Scoreboard monitor for the 128-bit instance: every valid cycle must show
    // the head of the queue; the entry retires when ready is also high.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pend_hold = 1'b0;
            end else begin
                if (pend_hold) check("hold_valid", seed_valid, 1);
                pend_hold = seed_valid && !seed_ready;
                if (seed_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_beat", seed_valid, 0);
                    end else begin
                        e = sb[0];
                        check("data", seed_data, e.dat);
                        check("leaf", seed_leaf, e.leaf);
                        check("beat", seed_beat, e.beat);
                        check("t", seed_t, e.t);
                        check("last", seed_last, e.last);
                        if (seed_ready) begin
                            e = sb.pop_front();
                            xfer_cnt++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && seed_valid2) begin
                if (sb2.size() == 0) begin
                    check("wide_unexpected_beat", seed_valid2, 0);
                end else begin
                    e = sb2[0];
                    check("wide_data", seed_data2, e.dat);
                    check("wide_leaf", seed_leaf2, e.leaf);
                    check("wide_beat", seed_beat2, e.beat);
                    check("wide_t", seed_t2, e.t);
                    check("wide_last", seed_last2, e.last);
                    if (seed_ready2) begin
                        e = sb2.pop_front();
                        xfer_cnt2++;
                    end
                end
            end
        end
    end

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while ((sb.size() != 0 || sb2.size() != 0) && n < bound) begin
            @(posedge clk);
            n++;
        end
        if (n >= bound) check("drain_timeout", sb.size() + sb2.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_xfer(input int target, input int bound);
        int n;
        n = 0;
        while (xfer_cnt < target && n < bound) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= bound) check("xfer_timeout", xfer_cnt, target);
    endtask

    // Called just after a posedge; holds the pulse across exactly one edge.
    task automatic pulse_tse(input logic [7:0] t);
        tree_set_end = 1'b1;
        t_in = t;
        @(posedge clk);
        #1;
        tree_set_end = 1'b0;
    endtask

    initial begin
        logic [2047:0] b;
        reset = 1'b0;
        seed_bundle = '0;
        t_in = '0;
        tree_set_end = 1'b0;
        tree_set_end2 = 1'b0;
        seed_ready2 = 1'b1;
        clr_overrun = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", seed_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_data", seed_data, 0);
        check("rst_leaf", seed_leaf, 0);
        check("rst_beat", seed_beat, 0);
        check("rst_t", seed_t, 0);
        check("rst_last", seed_last, 0);
        check("rst_wide_valid", seed_valid2, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: patterned bundle, ready steady, latency check
        for (int k = 0; k < 8; k++) b[2047 - k*256 -: 256] = {32{8'h10 + 8'(k)}};
        seed_bundle = b;
        xfer_cnt = 0;
        push_narrow(b, 8'h05);
        tree_set_end = 1'b1;
        t_in = 8'h05;
        check("lat_valid_before", seed_valid, 0);
        @(posedge clk);
        #1;
        tree_set_end = 1'b0;
        check("lat_valid_after", seed_valid, 1);
        check("lat_busy", busy, 1);
        wait_drain(100);
        check("t1_count", xfer_cnt, 16);
        check("t1_busy_end", busy, 0);
        check("t1_valid_end", seed_valid, 0);

        // 2: ready toggling 1,0,0,1
        ready_mode = 1;
        xfer_cnt = 0;
        b = rand_bundle();
        seed_bundle = b;
        push_narrow(b, 8'h05);
        pulse_tse(8'h05);
        seed_bundle = rand_bundle();
        t_in = 8'h77;
        wait_drain(200);
        check("t2_count", xfer_cnt, 16);
        ready_mode = 0;
        @(posedge clk);
        #1;

        // 3: overrun on beat 5, stream unaltered; set beats clear
        xfer_cnt = 0;
        b = rand_bundle();
        seed_bundle = b;
        push_narrow(b, 8'h05);
        pulse_tse(8'h05);
        wait_xfer(5, 50);
        seed_bundle = rand_bundle();
        pulse_tse(8'h06);
        check("ovr_set", overrun, 1);
        check("ovr_busy", busy, 1);
        seed_bundle = rand_bundle();
        t_in = 8'hAA;
        clr_overrun = 1'b1;
        pulse_tse(8'h06);
        clr_overrun = 1'b0;
        check("ovr_set_wins", overrun, 1);
        wait_drain(100);
        check("t3_count", xfer_cnt, 16);
        check("ovr_sticky", overrun, 1);
        clr_overrun = 1'b1;
        @(posedge clk);
        #1;
        clr_overrun = 1'b0;
        check("ovr_cleared", overrun, 0);

        // 4: new bundle exactly on the seed_last transfer
        xfer_cnt = 0;
        b = rand_bundle();
        seed_bundle = b;
        push_narrow(b, 8'h05);
        pulse_tse(8'h05);
        for (int c = 0; c < 100 && !seed_last; c++) begin
            @(posedge clk);
            #1;
        end
        check("t4_reach_last", seed_last, 1);
        b = rand_bundle();
        seed_bundle = b;
        push_narrow(b, 8'h06);
        pulse_tse(8'h06);
        check("b2b_valid", seed_valid, 1);
        check("b2b_leaf", seed_leaf, 0);
        check("b2b_beat", seed_beat, 0);
        check("b2b_t", seed_t, 8'h06);
        check("b2b_overrun", overrun, 0);
        wait_drain(100);
        check("t4_count", xfer_cnt, 32);

        // 5: reset mid-stream at beat 7
        xfer_cnt = 0;
        b = rand_bundle();
        seed_bundle = b;
        push_narrow(b, 8'h09);
        pulse_tse(8'h09);
        wait_xfer(7, 50);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", seed_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", seed_data, 0);
        check("mid_rst_leaf", seed_leaf, 0);
        check("mid_rst_beat", seed_beat, 0);
        check("mid_rst_t", seed_t, 0);
        check("mid_rst_last", seed_last, 0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_valid", seed_valid, 0);
        check("post_rst_busy", busy, 0);

        // 6: 256-bit build: 8 beats, full leaves
        xfer_cnt2 = 0;
        b = rand_bundle();
        seed_bundle = b;
        push_wide(b, 8'h33);
        tree_set_end2 = 1'b1;
        t_in = 8'h33;
        @(posedge clk);
        #1;
        tree_set_end2 = 1'b0;
        check("wide_valid", seed_valid2, 1);
        wait_drain(100);
        check("wide_count", xfer_cnt2, 8);
        check("wide_busy_end", busy2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
